keypad_entry: RTL
=================

Name: keypad_entry

Overview:
- Upstream front end for the room security controller.
- Conditions raw keypad and button signals: 2-flop synchronisers, then per-input debounce.
- Latches one 4-bit key code and issues a single-cycle enter strobe with a stable password_input, matching the controller's password_input/enter interface.
- Adds cancel and an inactivity timeout so stale partial entries never reach the lock controller.

Parameters:
- DEB_CYCLES, 16, consecutive stable cycles required before a debounced level changes (range 2..65535).
- TIMEOUT_CYCLES, 1000000, cycles a latched digit may wait for enter before being discarded (min 2).
- CNT_W, 20, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- key_raw  in  1  raw key-pressed level from keypad, asynchronous, bouncy.
- key_code  in  4  raw code of the pressed key; valid while key_raw is high.
- enter_raw  in  1  raw enter button, asynchronous, bouncy.
- cancel_raw  in  1  raw cancel button, asynchronous, bouncy.
- password_input  out  4  latched key code presented to the controller.
- enter  out  1  one-cycle submit strobe.
- digit_ready  out  1  high while a digit is latched and awaiting enter.
- entry_timeout  out  1  one-cycle pulse when a latched digit expires.

Behaviour:
- Reset: clear_n low asynchronously forces all registered state to zero.
  - Outputs: password_input=0, enter=0, digit_ready=0, entry_timeout=0.
  - Internal: state=IDLE, all synchronisers, debounced levels and counters=0.
  - Reset mid-entry discards the latched digit; no enter strobe is emitted.
- Synchronisation: key_raw, enter_raw, cancel_raw and key_code[3:0] each pass through 2 flops.
- Debounce, per input key/enter/cancel:
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments.
  - When it reaches DEB_CYCLES-1, the debounced level takes the synced level on the next edge and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced level.
- Events: key_evt, enter_evt and cancel_evt fire for one cycle on a debounced 0->1 transition only.
  - Releases generate no event; holding a button generates exactly one event.
  - key_evt samples the synced key_code on the same cycle.
- Latency: raw edge to event = 2 + DEB_CYCLES cycles.
  - FSM output changes 1 cycle after the event.
- Event priority on the same cycle: cancel > enter > key.
- FSM states: IDLE, HELD, SUBMIT.
  - IDLE, key_evt: latch code into password_input, set digit_ready=1, timer=0, go to HELD.
  - IDLE, enter_evt or cancel_evt: ignored, stay in IDLE.
  - HELD, cancel_evt: password_input=0, digit_ready=0, go to IDLE.
  - HELD, enter_evt: go to SUBMIT, with enter=1 for exactly that one cycle.
  - HELD, key_evt: overwrite password_input (last key wins), timer=0, stay in HELD.
  - HELD, otherwise: timer increments. When timer == TIMEOUT_CYCLES-1: password_input=0, digit_ready=0, entry_timeout=1 for one cycle, go to IDLE.
  - SUBMIT: enter=0, digit_ready=0, go to IDLE unconditionally. password_input stays held until the next key_evt latches a new code.
  - SUBMIT: any event arriving in this cycle is dropped.
- password_input is stable from the cycle before enter rises through the cycle after it falls.
- enter and entry_timeout are never high on the same cycle.
- The timer saturates and never wraps; the timeout takes priority over a same-cycle key_evt.

Decomposition:
- Shared package room_security_pkg:
  - state encoding typedef entry_state_t with values IDLE, HELD, SUBMIT.
  - constant KEY_W=4, shared with the lock controller's password width.
- Natural sub-module: debounce_sync, a 2-flop synchroniser plus DEB_CYCLES counter with a rising-edge event output.
  - Instantiated three times: key, enter, cancel.
  - key_code is synchronised separately without debounce.

Test Plan (DEB_CYCLES=4, TIMEOUT_CYCLES=50):
- Reset, then key_raw high with key_code=4'hA held 10 cycles -> digit_ready=1 and password_input=4'hA at cycle 7 after the edge; enter stays 0.
- After that, enter_raw pulse held 10 cycles -> exactly one enter=1 cycle with password_input=4'hA; digit_ready=0 afterwards.
- key_raw bouncing with 3-cycle pulses for 30 cycles, then low -> no event, digit_ready stays 0.
- Latch 4'h3, then press 4'h5 -> password_input=4'h5; after a further 50 idle cycles -> entry_timeout pulses once, password_input=0, no enter.
- Latch 4'h7, then cancel_raw and enter_raw rising together -> cancel wins: digit_ready=0, password_input=0, enter never asserted.
- Latch 4'hA, then clear_n low asynchronously mid-cycle during HELD -> outputs zero immediately; after release, enter_raw press produces no enter.

Source files
------------

// File: rtl/room_security_pkg.sv
// Shared types and constants for the room security front end and lock controller.
package room_security_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    SUBMIT = 2'd2
  } entry_state_t;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; emits a one-cycle
// pulse when the debounced level rises.
module debounce_sync #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic clear_n,
  input  logic raw,
  output logic rise
);

  logic [1:0]  sync;
  logic        level;
  logic [15:0] cnt;
  logic        differs;
  logic        settle;

  assign differs = (sync[1] != level);
  // The level commits on the edge after the counter has seen DEB_CYCLES-1
  // prior mismatching cycles, i.e. on the DEB_CYCLES-th consecutive mismatch.
  assign settle  = differs && (cnt == 16'(DEB_CYCLES - 1));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= settle && sync[1];
      if (!differs) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: conditions raw keypad/button inputs, latches one key code
// and presents it with a one-cycle enter strobe; cancel and timeout discard it.
module keypad_entry
  import room_security_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             key_raw,
  input  logic [KEY_W-1:0] key_code,
  input  logic             enter_raw,
  input  logic             cancel_raw,
  output logic [KEY_W-1:0] password_input,
  output logic             enter,
  output logic             digit_ready,
  output logic             entry_timeout
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             key_evt;
  logic             enter_evt;
  logic             cancel_evt;
  logic [KEY_W-1:0] code_s1;
  logic [KEY_W-1:0] code_s2;

  entry_state_t     state;
  entry_state_t     state_n;
  logic [KEY_W-1:0] pw;
  logic [KEY_W-1:0] pw_n;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  logic             timeout_q;
  logic             timeout_n;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clock   (clock),
    .clear_n (clear_n),
    .raw     (key_raw),
    .rise    (key_evt)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .clock   (clock),
    .clear_n (clear_n),
    .raw     (enter_raw),
    .rise    (enter_evt)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_cancel (
    .clock   (clock),
    .clear_n (clear_n),
    .raw     (cancel_raw),
    .rise    (cancel_evt)
  );

  // The code bus is only sampled while key is debounced high, so no debounce.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      code_s1 <= '0;
      code_s2 <= '0;
    end else begin
      code_s1 <= key_code;
      code_s2 <= code_s1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      pw        <= '0;
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      pw        <= pw_n;
      timer     <= timer_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    pw_n      = pw;
    timer_n   = timer;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        // A same-cycle cancel or enter outranks the key and swallows it.
        if (key_evt && !cancel_evt && !enter_evt) begin
          pw_n    = code_s2;
          timer_n = '0;
          state_n = HELD;
        end
      end
      HELD: begin
        if (cancel_evt) begin
          pw_n    = '0;
          state_n = IDLE;
        end else if (enter_evt) begin
          state_n = SUBMIT;
        end else if (timer == TIMER_LAST) begin
          pw_n      = '0;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else if (key_evt) begin
          pw_n    = code_s2;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      SUBMIT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign password_input = pw;
  assign enter          = (state == SUBMIT);
  assign digit_ready    = (state == HELD);
  assign entry_timeout  = timeout_q;

endmodule
